// File: rtl/dnu_wr_scheduler.sv
// Grants the shared IB-ROM/RAM write port to one DNU unit at a time, sweeping all units once per iteration.
// Optional watchdog enabled by defining DNU_WR_SCHED_WDT_EN.
module dnu_wr_scheduler #(
   parameter int NUM_UNITS = 4,
   parameter int MAX_ITER  = 8,
   parameter int WDT_LIMIT = 255
) (
   input  logic                         write_clk,
   input  logic                         rstn,
   input  logic                         iter_start,
   input  logic                         decode_term,
   input  logic [2*NUM_UNITS-1:0]       unit_busy,
   output logic [NUM_UNITS-1:0]         unit_iter_rqst,
   output logic [NUM_UNITS-1:0]         unit_iter_term,
   output logic [$clog2(NUM_UNITS)-1:0] grant_idx,
   output logic [7:0]                   iter_cnt,
   output logic                         sched_busy,
   output logic                         done,
   output logic                         timeout_err
);

   localparam int            GW       = $clog2(NUM_UNITS);
   localparam logic [GW-1:0] LastUnit = GW'(NUM_UNITS - 1);
   localparam logic [7:0]    IterMax  = 8'(MAX_ITER);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      RELEASE,
      ADVANCE,
      DONE
   } stateT;

   stateT         r_state;
   stateT         w_stateNext;
   logic [GW-1:0] r_grantIdx;
   logic [GW-1:0] w_grantNext;
   logic [7:0]    r_iterCnt;
   logic [7:0]    w_cntNext;
   logic [7:0]    w_cntInc;
   logic          r_termLatched;
   logic          w_termNext;
   logic [1:0]    w_grantBusy;
   logic          w_wdtExpired;

   // Only the granted unit's busy code is ever looked at.
   assign w_grantBusy = unit_busy[{r_grantIdx, 1'b0} +: 2];
   assign w_cntInc    = (r_iterCnt == 8'hFF) ? r_iterCnt : r_iterCnt + 8'd1;

`ifdef DNU_WR_SCHED_WDT_EN
   localparam int WW = $clog2(WDT_LIMIT + 1);

   logic [WW-1:0] r_wdtCnt;
   logic          r_timeoutErr;
   logic          w_wdtActive;

   assign w_wdtActive  = (r_state == REQ) || (r_state == LOAD) || (r_state == RELEASE);
   assign w_wdtExpired = w_wdtActive && (r_wdtCnt == WW'(WDT_LIMIT));

   // Each grant gets a fresh budget; the error flag stays set until reset.
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_wdtCnt     <= '0;
         r_timeoutErr <= 1'b0;
      end else begin
         if ((w_stateNext == REQ) && (r_state != REQ)) begin
            r_wdtCnt <= '0;
         end else if (w_wdtActive && !w_wdtExpired) begin
            r_wdtCnt <= r_wdtCnt + WW'(1);
         end
         if (w_wdtExpired) begin
            r_timeoutErr <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeoutErr;
`else
   assign w_wdtExpired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= IDLE;
         r_grantIdx    <= '0;
         r_iterCnt     <= '0;
         r_termLatched <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_grantIdx    <= w_grantNext;
         r_iterCnt     <= w_cntNext;
         r_termLatched <= w_termNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_grantNext = r_grantIdx;
      w_cntNext   = r_iterCnt;
      w_termNext  = r_termLatched;
      case (r_state)
         IDLE: begin
            if (iter_start) begin
               w_stateNext = REQ;
               w_grantNext = '0;
               w_cntNext   = '0;
               w_termNext  = 1'b0;
            end
         end
         REQ:     if (w_grantBusy == 2'b01) w_stateNext = LOAD;
         LOAD:    if (w_grantBusy == 2'b10) w_stateNext = RELEASE;
         RELEASE: if (w_grantBusy == 2'b00) w_stateNext = ADVANCE;
         ADVANCE: begin
            // An iteration completes only after the last unit has been served.
            if (r_grantIdx == LastUnit) begin
               w_grantNext = '0;
               w_cntNext   = w_cntInc;
               w_stateNext = ((w_cntInc == IterMax) || r_termLatched) ? DONE : REQ;
            end else if (r_termLatched) begin
               w_stateNext = DONE;
            end else begin
               w_grantNext = GW'(r_grantIdx + 1);
               w_stateNext = REQ;
            end
         end
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
      if (decode_term && (r_state != IDLE) && (r_state != DONE)) begin
         w_termNext = 1'b1;
      end
      if (w_wdtExpired) begin
         w_stateNext = DONE;
      end
   end

   always_comb begin
      unit_iter_rqst = '0;
      unit_iter_term = '0;
      if ((r_state == REQ) || (r_state == LOAD)) begin
         unit_iter_rqst[r_grantIdx] = 1'b1;
         unit_iter_term[r_grantIdx] = r_termLatched | decode_term;
      end
   end

   assign grant_idx  = r_grantIdx;
   assign iter_cnt   = r_iterCnt;
   assign sched_busy = (r_state != IDLE);
   assign done       = (r_state == DONE);

endmodule

// File: tb/tb_dnu_wr_scheduler.sv
// Scoreboard bench for dnu_wr_scheduler: behavioural DNU unit models, expected grant/done
// sequence derived per frame from the scheduling rules, monitor pops and compares.
module tb_dnu_wr_scheduler;

   localparam int N     = 4;
   localparam int MAXIT = 2;
   localparam int WDT   = 100;

   logic           write_clk = 1'b0;
   logic           rstn = 1'b0;
   logic           iter_start = 1'b0;
   logic           decode_term = 1'b0;
   logic [2*N-1:0] unit_busy;
   logic [N-1:0]   unit_iter_rqst;
   logic [N-1:0]   unit_iter_term;
   logic [1:0]     grant_idx;
   logic [7:0]     iter_cnt;
   logic           sched_busy;
   logic           done;
   logic           timeout_err;

   dnu_wr_scheduler #(
      .NUM_UNITS(N),
      .MAX_ITER (MAXIT),
      .WDT_LIMIT(WDT)
   ) dut (
      .write_clk     (write_clk),
      .rstn          (rstn),
      .iter_start    (iter_start),
      .decode_term   (decode_term),
      .unit_busy     (unit_busy),
      .unit_iter_rqst(unit_iter_rqst),
      .unit_iter_term(unit_iter_term),
      .grant_idx     (grant_idx),
      .iter_cnt      (iter_cnt),
      .sched_busy    (sched_busy),
      .done          (done),
      .timeout_err   (timeout_err)
   );

   always #5 write_clk = ~write_clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit isDone;
      int idx;
      int cnt;
      bit tmo;
   } expT;

   expT expQ[$];

   logic [1:0] modelBusy [N] = '{default: 2'b00};
   int  ph  [N] = '{default: 0};
   int  cyc [N] = '{default: 0};
   int  loadCount = 0;
   int  loadMin = 4;
   int  loadMax = 12;
   bit  hang = 1'b0;
   bit  ovrEn = 1'b0;
   int  ovrUnit = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   always_comb begin
      unit_busy = '0;
      for (int k = 0; k < N; k++) begin
         unit_busy[2*k +: 2] = (ovrEn && (ovrUnit == k)) ? 2'b11 : modelBusy[k];
      end
   end

   // Unit models: 01 two cycles after a request, 10 after the load time, 00 two cycles after release.
   always @(posedge write_clk) begin
      #1;
      for (int k = 0; k < N; k++) begin
         if (!rstn) begin
            ph[k] = 0;
            cyc[k] = 0;
            modelBusy[k] = 2'b00;
         end else begin
            case (ph[k])
               0: if (unit_iter_rqst[k]) begin ph[k] = 1; cyc[k] = 2; end
               1: begin
                  cyc[k]--;
                  if (cyc[k] == 0) begin
                     modelBusy[k] = 2'b01;
                     ph[k] = 2;
                     cyc[k] = $urandom_range(loadMax, loadMin);
                     loadCount++;
                  end
               end
               2: begin
                  if (!hang) cyc[k]--;
                  if (cyc[k] == 0) begin modelBusy[k] = 2'b10; ph[k] = 3; end
               end
               3: if (!unit_iter_rqst[k]) begin ph[k] = 4; cyc[k] = 2; end
               default: begin
                  cyc[k]--;
                  if (cyc[k] == 0) begin modelBusy[k] = 2'b00; ph[k] = 0; end
               end
            endcase
         end
      end
   end

   // Monitor: every new request and every done pulse consumes one scoreboard entry.
   logic [N-1:0] prevRqst = '0;
   always @(posedge write_clk) begin
      expT e;
      #3;
      if (!rstn) begin
         prevRqst = '0;
      end else begin
         if ((unit_iter_rqst != '0) && (prevRqst == '0)) begin
            if ((expQ.size() == 0) || expQ[0].isDone) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedGrant: got rqst=%b, want no grant", unit_iter_rqst);
            end else begin
               e = expQ.pop_front();
               checkOutput("grantRqst", int'(unit_iter_rqst), 1 << e.idx);
               checkOutput("grantIdx", int'(grant_idx), e.idx);
               checkOutput("grantIterCnt", int'(iter_cnt), e.cnt);
            end
         end
         if (done) begin
            if ((expQ.size() == 0) || !expQ[0].isDone) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedDone: got done=1, want 0");
            end else begin
               e = expQ.pop_front();
               checkOutput("doneIterCnt", int'(iter_cnt), e.cnt);
               checkOutput("doneTimeout", int'(timeout_err), int'(e.tmo));
               checkOutput("doneRqst", int'(unit_iter_rqst), 0);
            end
         end
         prevRqst = unit_iter_rqst;
      end
   end

   // Reference: units are served in order 0..N-1 each iteration; a termination ends the
   // frame after the unit it hit, counting the iteration only if that was the last unit.
   function automatic int pushFrame(input int termIter, input int termUnit);
      int  expCnt;
      bit  stop;
      expT e;
      stop = 1'b0;
      for (int it = 0; it < MAXIT && !stop; it++) begin
         for (int u = 0; u < N && !stop; u++) begin
            e = '{isDone: 1'b0, idx: u, cnt: it, tmo: 1'b0};
            expQ.push_back(e);
            if ((it == termIter) && (u == termUnit)) stop = 1'b1;
         end
      end
      if (termIter < 0) expCnt = MAXIT;
      else expCnt = (termUnit == N - 1) ? termIter + 1 : termIter;
      e = '{isDone: 1'b1, idx: 0, cnt: expCnt, tmo: 1'b0};
      expQ.push_back(e);
      return expCnt;
   endfunction

   task automatic waitLoads(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge write_clk);
         if (loadCount >= target) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL loadWait: got %0d loads, want %0d", loadCount, target);
      end
   endtask

   task automatic recover();
      expQ.delete();
      @(negedge write_clk);
      rstn = 1'b0;
      hang = 1'b0;
      ovrEn = 1'b0;
      decode_term = 1'b0;
      repeat (3) @(negedge write_clk);
      rstn = 1'b1;
   endtask

   task automatic pulseStart();
      @(negedge write_clk);
      iter_start = 1'b1;
      @(negedge write_clk);
      iter_start = 1'b0;
   endtask

   task automatic finishFrame(input int expCnt);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge write_clk);
         if (done) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL doneWait: got no done pulse, want one");
         recover();
      end else begin
         @(negedge write_clk);
         checkOutput("idleBusy", int'(sched_busy), 0);
         checkOutput("queueEmpty", expQ.size(), 0);
         repeat (3) @(negedge write_clk);
         checkOutput("cntHeld", int'(iter_cnt), expCnt);
      end
   endtask

   task automatic applyStimulus(input int termIter, input int termUnit, input int lmin,
                                input int lmax, input bit extraStart);
      int expCnt;
      bit ok;
      loadMin = lmin;
      loadMax = lmax;
      loadCount = 0;
      expCnt = pushFrame(termIter, termUnit);
      pulseStart();
      if (extraStart) begin
         waitLoads(2, ok);
         pulseStart();
      end
      if (termIter >= 0) begin
         waitLoads(termIter * N + termUnit + 1, ok);
         if (ok) begin
            @(posedge write_clk);
            @(negedge write_clk);
            decode_term = 1'b1;
            #1 checkOutput("termOut", int'(unit_iter_term), 1 << termUnit);
            @(negedge write_clk);
            decode_term = 1'b0;
            #1 checkOutput("termLatched", int'(unit_iter_term), 1 << termUnit);
         end
      end
      finishFrame(expCnt);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Rqst"}, int'(unit_iter_rqst), 0);
      checkOutput({tag, "Term"}, int'(unit_iter_term), 0);
      checkOutput({tag, "Grant"}, int'(grant_idx), 0);
      checkOutput({tag, "Cnt"}, int'(iter_cnt), 0);
      checkOutput({tag, "Busy"}, int'(sched_busy), 0);
      checkOutput({tag, "Done"}, int'(done), 0);
      checkOutput({tag, "Tmo"}, int'(timeout_err), 0);
   endtask

   initial begin
      int  expCnt;
      int  r;
      bit  ok;
      expT e;

      repeat (3) @(negedge write_clk);
      checkAllZero("reset");
      rstn = 1'b1;

      $display("[TB] normal frame, long loads");
      applyStimulus(-1, 0, 64, 64, 1'b0);

      $display("[TB] start while busy is ignored");
      applyStimulus(-1, 0, 4, 12, 1'b1);

      $display("[TB] early termination at unit 1, iteration 0");
      applyStimulus(0, 1, 8, 8, 1'b0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 8; f++) begin
         if ($urandom_range(1, 0) == 1) begin
            @(negedge write_clk);
            decode_term = 1'b1;
            @(negedge write_clk);
            decode_term = 1'b0;
         end
         r = $urandom_range(MAXIT, 0);
         applyStimulus(r - 1, $urandom_range(N - 1, 0), 4, 12, 1'b0);
      end

      $display("[TB] illegal busy code on granted unit");
      loadMin = 20;
      loadMax = 20;
      loadCount = 0;
      expCnt = pushFrame(-1, 0);
      pulseStart();
      waitLoads(1, ok);
      @(posedge write_clk);
      @(negedge write_clk);
      ovrUnit = 0;
      ovrEn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge write_clk);
         checkOutput("illegalHold", int'(unit_iter_rqst), 1);
      end
      ovrEn = 1'b0;
      finishFrame(expCnt);

      $display("[TB] reset during load of unit 2");
      loadMin = 10;
      loadMax = 10;
      loadCount = 0;
      for (int u = 0; u < 3; u++) begin
         e = '{isDone: 1'b0, idx: u, cnt: 0, tmo: 1'b0};
         expQ.push_back(e);
      end
      pulseStart();
      waitLoads(3, ok);
      @(posedge write_clk);
      repeat (3) @(negedge write_clk);
      rstn = 1'b0;
      #1 checkAllZero("midReset");
      checkOutput("queueAfterReset", expQ.size(), 0);
      expQ.delete();
      repeat (3) @(negedge write_clk);
      rstn = 1'b1;
      applyStimulus(-1, 0, 4, 8, 1'b0);

      $display("[TB] unit never finishes");
      hang = 1'b1;
      loadMin = 4;
      loadMax = 4;
      loadCount = 0;
      e = '{isDone: 1'b0, idx: 0, cnt: 0, tmo: 1'b0};
      expQ.push_back(e);
`ifdef DNU_WR_SCHED_WDT_EN
      e = '{isDone: 1'b1, idx: 0, cnt: 0, tmo: 1'b1};
      expQ.push_back(e);
      pulseStart();
      finishFrame(0);
      checkOutput("wdtSticky", int'(timeout_err), 1);
      checkOutput("wdtRqst", int'(unit_iter_rqst), 0);
`else
      pulseStart();
      repeat (300) @(negedge write_clk);
      checkOutput("hangRqst", int'(unit_iter_rqst), 1);
      checkOutput("hangTmo", int'(timeout_err), 0);
      checkOutput("hangBusy", int'(sched_busy), 1);
      checkOutput("hangQueue", expQ.size(), 0);
`endif
      rstn = 1'b0;
      #1 checkAllZero("hangReset");
      hang = 1'b0;
      expQ.delete();
      repeat (3) @(negedge write_clk);
      rstn = 1'b1;
      repeat (3) @(negedge write_clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
